// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register lane map,
// status bit positions, serializer states and the divisor clamp helper.
package wb_uart_tx_pkg;

    localparam int LANE_TX     = 0;
    localparam int LANE_STATUS = 1;
    localparam int LANE_DIV_LO = 4;
    localparam int LANE_DIV_HI = 5;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_e;

    // A divisor below 2 cannot frame a bit, so it is raised to the minimum.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/wb_uart_tx_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy counter that
// drives full/empty. Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter: register decode, TX FIFO and a
// bit serializer with a runtime-programmable baud divisor.
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    output logic                    ack_o,
    output logic                    tx_o,
    output logic                    irq_o,
    output ser_state_e              dbg_state_o
);

    localparam int NLANES = DATA_WIDTH / 8;

    // Handshake: a request is stb_i&cyc_i while no ack is outstanding; ack_o
    // rises one cycle later for one cycle, and every register effect and the
    // read data take effect at that same edge.
    logic                  req, wr, rd;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d, rd_data;
    logic                  ovf_q, ovf_d;
    logic [15:0]           div_q, div_d, div_wr;
    logic [7:0]            status;

    ser_state_e            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    logic                  push_req, fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty;
    logic [7:0]            fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic                  unused_ok;
    assign unused_ok = ^{adr_i, dat_i, sel_i, fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (dat_i[LANE_TX*8 +: 8]),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req       = stb_i && cyc_i && !ack_q;
    assign wr        = req && we_i;
    assign rd        = req && !we_i;
    assign push_req  = wr && sel_i[LANE_TX];
    // Full is judged before any same-cycle pop, so a push on a full FIFO drops.
    assign fifo_push = push_req && !fifo_full;

    always_comb begin
        status          = '0;
        status[ST_OVF]  = ovf_q;
        status[ST_BUSY] = (state_q != S_IDLE);
        status[ST_EMPTY]= fifo_empty;
        status[ST_FULL] = fifo_full;

        rd_data = '0;
        rd_data[LANE_STATUS*8 +: 8]  = status;
        rd_data[LANE_DIV_LO*8 +: 16] = div_q;
        for (int i = 0; i < NLANES; i++) begin
            if (!sel_i[i]) rd_data[i*8 +: 8] = '0;
        end

        ack_d   = req;
        dat_o_d = rd ? rd_data : '0;

        ovf_d = ovf_q;
        if (wr && sel_i[LANE_STATUS] && dat_i[LANE_STATUS*8 + ST_OVF]) ovf_d = 1'b0;
        if (push_req && fifo_full) ovf_d = 1'b1;

        div_wr = {sel_i[LANE_DIV_HI] ? dat_i[LANE_DIV_HI*8 +: 8] : div_q[15:8],
                  sel_i[LANE_DIV_LO] ? dat_i[LANE_DIV_LO*8 +: 8] : div_q[7:0]};
        div_d  = div_q;
        if (wr && (sel_i[LANE_DIV_HI] || sel_i[LANE_DIV_LO])) div_d = clamp_div(div_wr);
    end

    // Each bit reloads its countdown from div_q, so divisor changes apply at
    // the next bit boundary.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        bit_end  = (cnt_q == 16'd0);
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    cnt_d    = div_q - 16'd1;
                    tx_d     = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = div_q - 16'd1;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        cnt_d    = div_q - 16'd1;
                        tx_d     = 1'b0;
                        state_d  = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= 16'(DIV_RESET);
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign ack_o       = ack_q;
    assign dat_o       = dat_o_q;
    assign tx_o        = tx_q;
    assign irq_o       = fifo_empty && (state_q == S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: a frame-level reference model checked every cycle,
// directed register/timing scenarios and a randomized bus phase.
module tb_wb_uart_tx;
    import wb_uart_tx_pkg::*;

    localparam int DW    = 128;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int DIVR  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0]   b_adr;
    logic [DW-1:0]   b_dat;
    logic            b_we, b_stb, b_cyc;
    logic [DW/8-1:0] b_sel;
    logic [DW-1:0]   dat_o;
    logic            ack_o, tx_o, irq_o;
    ser_state_e      dbg_state;

    wb_uart_tx #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (DIVR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adr_i       (b_adr),
        .dat_i       (b_dat),
        .dat_o       (dat_o),
        .we_i        (b_we),
        .sel_i       (b_sel),
        .stb_i       (b_stb),
        .cyc_i       (b_cyc),
        .ack_o       (ack_o),
        .tx_o        (tx_o),
        .irq_o       (irq_o),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is the 10-bit line vector {stop, data, start}; each bit holds
    // for the divisor value current when that bit begins.
    logic [7:0]    mq[$];
    logic          m_active, m_ovf, m_ack, m_tx, m_req;
    logic [9:0]    m_frame;
    int            m_idx, m_rem, m_sz;
    logic [15:0]   m_div, m_nd;
    logic [DW-1:0] m_dat;

    task automatic model_start_frame();
        logic [7:0] b;
        b        = mq.pop_front();
        m_frame  = {1'b1, b, 1'b0};
        m_idx    = 0;
        m_rem    = m_div;
        m_tx     = 1'b0;
        m_active = 1'b1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_active = 1'b0;
            m_frame  = '0;
            m_idx    = 0;
            m_rem    = 0;
            m_div    = 16'(DIVR);
            m_ovf    = 1'b0;
            m_ack    = 1'b0;
            m_tx     = 1'b1;
            m_dat    = '0;
        end else begin
            m_req = b_stb && b_cyc && !m_ack;
            m_sz  = mq.size();
            m_dat = '0;
            if (m_req && !b_we) begin
                m_dat[15:8]  = {4'b0, m_ovf, m_active, m_sz == 0, m_sz == DEPTH};
                m_dat[47:32] = m_div;
                for (int i = 0; i < DW/8; i++)
                    if (!b_sel[i]) m_dat[i*8 +: 8] = 8'h00;
            end
            if (!m_active) begin
                if (m_sz > 0) model_start_frame();
            end else if (m_rem > 1) begin
                m_rem--;
            end else if (m_idx == 9) begin
                if (m_sz > 0) model_start_frame();
                else begin
                    m_active = 1'b0;
                    m_tx     = 1'b1;
                end
            end else begin
                m_idx++;
                m_rem = m_div;
                m_tx  = m_frame[m_idx];
            end
            if (m_req && b_we) begin
                if (b_sel[1] && b_dat[11]) m_ovf = 1'b0;
                if (b_sel[0]) begin
                    if (m_sz == DEPTH) m_ovf = 1'b1;
                    else mq.push_back(b_dat[7:0]);
                end
                if (b_sel[4] || b_sel[5]) begin
                    m_nd  = {b_sel[5] ? b_dat[47:40] : m_div[15:8],
                             b_sel[4] ? b_dat[39:32] : m_div[7:0]};
                    m_div = (m_nd < 16'd2) ? 16'd2 : m_nd;
                end
            end
            m_ack = m_req;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("tx_o",  DW'(tx_o),  DW'(m_tx));
        check("ack_o", DW'(ack_o), DW'(m_ack));
        check("dat_o", dat_o, m_dat);
        check("irq_o", DW'(irq_o), DW'(mq.size() == 0 && !m_active));
        check("busy",  DW'(dbg_state != S_IDLE), DW'(m_active));
    end

    // ---------------- driver tasks ----------------
    task automatic bus_op(input logic we, input logic [DW/8-1:0] sel,
                          input logic [DW-1:0] dat, output logic [DW-1:0] rdat);
        int k;
        @(negedge clk);
        b_adr = AW'($urandom);
        b_we  = we;
        b_sel = sel;
        b_dat = dat;
        b_stb = 1'b1;
        b_cyc = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ack_o && k < 4);
        if (!ack_o) check("ack_timeout", 0, 1);
        rdat  = dat_o;
        b_stb = 1'b0;
        b_cyc = 1'b0;
        b_we  = 1'b0;
        b_sel = '0;
    endtask

    task automatic wb_write(input logic [DW/8-1:0] sel, input logic [DW-1:0] dat);
        logic [DW-1:0] unused_r;
        bus_op(1'b1, sel, dat, unused_r);
    endtask

    task automatic wb_read(input logic [DW/8-1:0] sel, output logic [DW-1:0] rdat);
        bus_op(1'b0, sel, {4{$urandom}}, rdat);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (!(irq_o && dbg_state == S_IDLE) && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] rdat;
    logic [9:0]    pat;
    logic [5:0]    ack_pat;
    int            op;

    initial begin
        rst   = 1'b0;
        b_adr = '0;
        b_dat = '0;
        b_we  = 1'b0;
        b_sel = '0;
        b_stb = 1'b0;
        b_cyc = 1'b0;
        wait_cycles(3);
        check("reset_tx",  DW'(tx_o),  1);
        check("reset_irq", DW'(irq_o), 1);
        check("reset_ack", DW'(ack_o), 0);
        rst = 1'b1;
        wait_cycles(2);

        // Status read after reset: only the selected lane carries data.
        wb_read(16'h0002, rdat);
        check("reset_status", rdat, 128'h0200);
        @(negedge clk);
        check("ack_single", DW'(ack_o), 0);

        // 0x55 at divisor 16: alternating line, one bit per 16 clocks.
        wb_write(16'h0030, 128'h0010_0000_0000);
        wb_write(16'h0001, 128'h55);
        check("tx_before_start", DW'(tx_o), 1);
        @(negedge clk);
        check("start_edge", DW'(tx_o), 0);
        wait_cycles(7);
        pat = 10'b1010101010;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("frame55_bit%0d", k), DW'(tx_o), DW'(pat[k]));
            wait_cycles(16);
        end
        check("irq_after_frame", DW'(irq_o), 1);

        // Ten pushes during the first frame: the ninth fits, the tenth overflows.
        for (int k = 0; k < 10; k++) wb_write(16'h0001, DW'($urandom_range(0, 255)));
        wb_read(16'h0002, rdat);
        check("status_overflow", rdat, 128'h0D00);
        wb_write(16'h0002, 128'h0800);
        wb_read(16'h0002, rdat);
        check("status_w1c", rdat, 128'h0500);
        wait_idle(4000);

        // Divisor 0 clamps to 2.
        wb_write(16'h0030, 128'h0);
        wb_read(16'h0030, rdat);
        check("div_clamp", rdat, 128'h0002_0000_0000);
        wb_write(16'h0001, 128'h0F);
        @(negedge clk);
        check("div2_start0", DW'(tx_o), 0);
        @(negedge clk);
        check("div2_start1", DW'(tx_o), 0);
        @(negedge clk);
        check("div2_bit0", DW'(tx_o), 1);
        wait_idle(200);

        // Held strobe: a pending ack blocks the next request for one cycle.
        @(negedge clk);
        b_we  = 1'b0;
        b_sel = 16'h0002;
        b_stb = 1'b1;
        b_cyc = 1'b1;
        ack_pat = '0;
        ack_pat[0] = ack_o;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            ack_pat[i] = ack_o;
        end
        b_stb = 1'b0;
        b_cyc = 1'b0;
        check("held_stb_acks", DW'(ack_pat), DW'(6'b101010));

        // Randomized bus traffic with small divisors.
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: wb_write(16'h0001 | (16'($urandom) & 16'hFFCC), {4{$urandom}});
                4: wb_read(16'($urandom), rdat);
                5: begin
                    rdat = {4{$urandom}};
                    rdat[47:32] = 16'($urandom_range(0, 5));
                    wb_write(16'h0010 | (16'($urandom) & 16'h0020), rdat);
                end
                6: wb_write(16'h0002, {4{$urandom}});
                7: begin
                    @(negedge clk);
                    b_stb = 1'b1;
                    @(negedge clk);
                    b_stb = 1'b0;
                    b_cyc = 1'b1;
                    @(negedge clk);
                    b_cyc = 1'b0;
                end
                default: wait_cycles($urandom_range(1, 40));
            endcase
        end
        wait_idle(3000);

        // Reset during DATA bit 3 with a second byte queued.
        wb_write(16'h0030, 128'h0010_0000_0000);
        wb_write(16'h0001, 128'hA5);
        wb_write(16'h0001, 128'h3C);
        wait_cycles(70);
        check("pre_reset_state", DW'(dbg_state), DW'(S_DATA));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_tx", DW'(tx_o), 1);
        check("async_reset_state", DW'(dbg_state), DW'(S_IDLE));
        wait_cycles(3);
        rst = 1'b1;
        wb_read(16'h0032, rdat);
        check("post_reset_status", rdat, 128'h0010_0000_0200);
        wait_cycles(100);
        check("post_reset_tx_idle", DW'(tx_o), 1);
        check("post_reset_irq", DW'(irq_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, 128, Wishbone data width in bits; byte granularity.
REQ-002 Parameter ADDR_WIDTH, 16, Wishbone byte-address width.
REQ-003 Parameter FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
REQ-004 Parameter DIV_RESET, 16, reset value of the baud divisor (clocks per bit), at least 2.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 adr_i  input  ADDR_WIDTH  byte address; ignored, block decodes as a single 16-byte word (upstream decode selects it).
REQ-008 dat_i  input  DATA_WIDTH  write data.
REQ-009 dat_o  output  DATA_WIDTH  read data.
REQ-010 we_i  input  1  write enable.
REQ-011 sel_i  input  DATA_WIDTH/8  byte-lane selects.
REQ-012 stb_i, cyc_i  input  1 each  Wishbone strobe and cycle.
REQ-013 ack_o  output  1  Wishbone acknowledge.
REQ-014 tx_o  output  1  serial line, idle high.
REQ-015 irq_o  output  1  level interrupt: FIFO empty AND serializer idle.

Function
REQ-016 Register map (byte lanes): lane 0 W = TX push; lane 1 R = status {bit3 overflow, bit2 busy, bit1 empty, bit0 full}, W1C bit3; lanes 5:4 RW = divisor[15:0]; all other lanes read 0, writes ignored.
REQ-017 ack_o asserts exactly one cycle after a cycle with stb_i&cyc_i&!ack_o, for one cycle only; no back-to-back acks; register side effects occur on the cycle ack_o asserts.
REQ-018 dat_o is valid while ack_o is high and 0 otherwise; reads have no side effects.
REQ-019 Lane-0 write with FIFO not full pushes dat_i[7:0]; with FIFO full the byte is dropped and overflow sets (sticky).
REQ-020 Simultaneous push and serializer pop on a full FIFO: push is rejected (full evaluated before pop).
REQ-021 Divisor write of 0 or 1 stores 2; new divisor takes effect at the next bit boundary.
REQ-022 Serializer states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop that cycle); START, each DATA bit, STOP each last divisor clocks; DATA sends 8 bits LSB first; STOP->START if FIFO non-empty else IDLE.
REQ-023 8N1 framing: start 0, 8 data, stop 1; tx_o registered; first start-bit edge 2 cycles after the acking write into an empty idle block.
REQ-024 busy = state != IDLE; empty/full from FIFO occupancy counter (0..FIFO_DEPTH) with wrapping read/write pointers.
REQ-025 If stb_i drops before ack_o, the pending ack still issues (classic responder, no abort).

Reset
REQ-026 Reset values: ack_o 0, dat_o 0, tx_o 1, irq_o 1, state IDLE, FIFO empty, pointers 0, overflow 0, divisor DIV_RESET, bit counter 0.
REQ-027 Reset mid-frame aborts immediately: tx_o 1 asynchronously, queued bytes discarded.

Structure
REQ-028 Shared package holds register lane offsets, status bit positions and the serializer state enum.
REQ-029 One sub-module, sync_fifo (width 8, depth FIFO_DEPTH, count output); Wishbone decode and serializer live in wb_uart_tx.

Verification
REQ-030 Write 0x55 to lane 0, divisor 16 -> ack next cycle; tx_o shows 0,1,0,1,0,1,0,1,0,1 each 16 clocks, then idle; irq_o returns to 1.
REQ-031 9 pushes while first byte transmits -> 9th accepted (FIFO drained 1); 10th push -> status reads 0x0D (overflow|busy|full); W1C 0x08 on lane 1 clears bit3.
REQ-032 Write divisor 0x0000 -> read back 0x0002; frame bit width 2 clocks.
REQ-033 Read lane 1 after reset -> dat_o[15:8]=0x02, all other bytes 0, ack single cycle.
REQ-034 Assert rst low during DATA bit 3 -> tx_o 1 same cycle, status empty after release, no further frames.
REQ-035 Held stb_i&cyc_i for 6 cycles -> ack_o high on cycles 2, 4, 6 only.
